// File: rtl/aes_host_pkg.sv
// Shared types and frame layout for the AES chip serial host.
// The frame is sent MSB first: {mode, key, addr, loc}.
package aes_host_pkg;

  localparam int unsigned FRAME_BITS = 145;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned ADDR_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    WAIT_DONE
  } state_t;

  function automatic logic [FRAME_BITS-1:0] pack_frame(
    input logic              mode,
    input logic [KEY_W-1:0]  key,
    input logic [ADDR_W-1:0] addr,
    input logic [ADDR_W-1:0] loc
  );
    return {mode, key, addr, loc};
  endfunction

endpackage

// File: rtl/aes_host_bit_timer.sv
// Serial bit-period divider: bit_tick marks the last clk cycle of each
// CLK_DIV-cycle bit period. Synchronous clear holds the divider at zero.
module aes_host_bit_timer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign bit_tick = !clear && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/aes_spi_host.sv
// Host sequencer for the AES chip serial port: sends one 145-bit job frame
// on ss/mosi, then waits for a miso rising edge or a timeout.
module aes_spi_host
  import aes_host_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_mode,
  input  logic [127:0] req_key,
  input  logic [7:0]   req_addr,
  input  logic [7:0]   req_loc,
  output logic         ss,
  output logic         mosi,
  input  logic         miso,
  output logic         busy,
  output logic         done_pulse,
  output logic         timeout_err
);

  localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  LAST_BIT = 8'(FRAME_BITS - 1);

  state_t                state, state_next;
  logic [FRAME_BITS-1:0] frame_q, frame_next;
  logic [7:0]            bit_cnt, bit_cnt_next;
  logic [TO_W-1:0]       to_cnt, to_cnt_next, to_inc;
  logic                  miso_q, miso_rise, to_hit;
  logic                  ss_next, mosi_next, done_next, timeout_next;
  logic                  bit_tick, timer_clear;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign timer_clear = !((state == SETUP) || (state == SHIFT));
  assign miso_rise   = miso && !miso_q;
  assign to_inc      = to_cnt + TO_W'(1);
  assign to_hit      = (to_inc == TO_W'(TIMEOUT));

  aes_host_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      frame_q     <= '0;
      bit_cnt     <= '0;
      to_cnt      <= '0;
      miso_q      <= 1'b0;
      ss          <= 1'b1;
      mosi        <= 1'b0;
      done_pulse  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      frame_q     <= frame_next;
      bit_cnt     <= bit_cnt_next;
      to_cnt      <= to_cnt_next;
      miso_q      <= miso;
      ss          <= ss_next;
      mosi        <= mosi_next;
      done_pulse  <= done_next;
      timeout_err <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state;
    frame_next   = frame_q;
    bit_cnt_next = bit_cnt;
    to_cnt_next  = '0;
    ss_next      = ss;
    mosi_next    = mosi;
    done_next    = 1'b0;
    timeout_next = 1'b0;

    case (state)
      IDLE: begin
        ss_next   = 1'b1;
        mosi_next = 1'b0;
        if (req_valid) begin
          frame_next   = pack_frame(req_mode, req_key, req_addr, req_loc);
          bit_cnt_next = '0;
          ss_next      = 1'b0;
          state_next   = SETUP;
        end
      end

      SETUP: begin
        if (bit_tick) begin
          mosi_next    = frame_q[FRAME_BITS-1];
          frame_next   = {frame_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_next = '0;
          state_next   = SHIFT;
        end
      end

      SHIFT: begin
        // mosi is loaded one period ahead, so bit_cnt names the bit on the wire
        if (bit_tick) begin
          if (bit_cnt == LAST_BIT) begin
            ss_next    = 1'b1;
            mosi_next  = 1'b0;
            state_next = WAIT_DONE;
          end else begin
            bit_cnt_next = bit_cnt + 8'd1;
            mosi_next    = frame_q[FRAME_BITS-1];
            frame_next   = {frame_q[FRAME_BITS-2:0], 1'b0};
          end
        end
      end

      WAIT_DONE: begin
        to_cnt_next = to_inc;
        // Done takes priority when the edge lands on the timeout cycle.
        if (miso_rise) begin
          done_next   = 1'b1;
          to_cnt_next = '0;
          state_next  = IDLE;
        end else if (to_hit) begin
          timeout_next = 1'b1;
          to_cnt_next  = '0;
          state_next   = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_spi_host.sv
// Directed bench for aes_spi_host: reset, frame serialisation, done/stale/
// timeout handling, done-vs-timeout priority and mid-frame reset.
module tb_aes_spi_host;

  localparam int DIV = 4;
  localparam int TMO = 100;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         req_mode;
  logic [127:0] req_key;
  logic [7:0]   req_addr;
  logic [7:0]   req_loc;
  logic         ss;
  logic         mosi;
  logic         miso;
  logic         busy;
  logic         done_pulse;
  logic         timeout_err;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int tmo_cnt  = 0;

  aes_spi_host #(
    .CLK_DIV(DIV),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_key    (req_key),
    .req_addr   (req_addr),
    .req_loc    (req_loc),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso),
    .busy       (busy),
    .done_pulse (done_pulse),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done_pulse === 1'b1) done_cnt = done_cnt + 1;
    if (timeout_err === 1'b1) tmo_cnt = tmo_cnt + 1;
  end

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns just after the accept edge (cycle A+1); inputs are scrambled after.
  task automatic start_job(input logic m, input logic [127:0] k, input logic [7:0] a,
                           input logic [7:0] l);
    check("ready_before_accept", req_ready, 1);
    req_mode  = m;
    req_key   = k;
    req_addr  = a;
    req_loc   = l;
    req_valid = 1'b1;
    step(1);
    req_valid = 1'b0;
    req_mode  = ~m;
    req_key   = ~k;
    req_addr  = ~a;
    req_loc   = ~l;
  endtask

  // Called at cycle A+1; returns at the first cycle with ss high (W).
  task automatic run_frame(output logic [144:0] got, output int low);
    int r;
    int k;
    got = '0;
    low = 0;
    r   = 1;
    while (ss === 1'b0 && r < 2000) begin
      low = low + 1;
      if (r > DIV && ((r - 1 - DIV / 2) % DIV) == 0) begin
        k = (r - 1 - DIV / 2) / DIV - 1;
        if (k < 145) got[144 - k] = mosi;
      end
      step(1);
      r = r + 1;
    end
  endtask

  logic [144:0] got;
  logic [144:0] exp_nom;
  logic [144:0] exp_stale;
  logic [144:0] exp_fresh;
  int low;
  int d0;
  int t0;

  initial begin
    exp_nom   = {1'b1, 128'h000102030405060708090a0b0c0d0e0f, 8'h10, 8'h20};
    exp_stale = {1'b0, 128'hfedcba98765432100123456789abcdef, 8'ha5, 8'h3c};
    exp_fresh = {1'b1, 128'h55aa55aa00ff00ff1234567887654321, 8'h01, 8'hfe};

    rst = 1'b1; req_valid = 1'b0; req_mode = 1'b0; req_key = '0;
    req_addr = '0; req_loc = '0; miso = 1'b0;
    step(3);
    check("rst_ss", ss, 1);
    check("rst_mosi", mosi, 0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done_pulse, 0);
    check("rst_tmo", timeout_err, 0);
    rst = 1'b0;
    step(2);

    // Nominal frame
    start_job(1'b1, 128'h000102030405060708090a0b0c0d0e0f, 8'h10, 8'h20);
    check("nom_ss_fall", ss, 0);
    check("nom_busy", busy, 1);
    check("nom_ready_low", req_ready, 0);
    run_frame(got, low);
    check("nom_ss_low_cycles", low, 584);
    check("nom_frame", got, exp_nom);
    check("nom_first_bit", got[144], 1);
    check("nom_last_byte", got[7:0], 8'h20);
    check("nom_wait_mosi", mosi, 0);
    check("nom_wait_busy", busy, 1);
    d0 = done_cnt;
    step(40);
    check("nom_no_early_done", done_cnt - d0, 0);
    miso = 1'b1;
    step(1);
    check("nom_done", done_pulse, 1);
    check("nom_done_ready", req_ready, 1);
    check("nom_no_tmo", timeout_err, 0);

    // Back-to-back accept at E+1; miso stays high for the stale test
    start_job(1'b0, 128'hfedcba98765432100123456789abcdef, 8'ha5, 8'h3c);
    check("b2b_ss_fall", ss, 0);
    check("nom_done_single", done_pulse, 0);
    check("nom_done_count", done_cnt - d0, 1);
    run_frame(got, low);
    check("stale_frame", got, exp_stale);
    check("stale_ss_low_cycles", low, 584);
    d0 = done_cnt;
    step(5);
    check("stale_ignored", done_cnt - d0, 0);
    miso = 1'b0;
    step(3);
    check("stale_low_no_done", done_cnt - d0, 0);
    miso = 1'b1;
    step(1);
    check("stale_done", done_pulse, 1);
    step(1);
    check("stale_done_count", done_cnt - d0, 1);

    // Timeout
    miso = 1'b0;
    step(2);
    d0 = done_cnt; t0 = tmo_cnt;
    start_job(1'b1, 128'h0, 8'h00, 8'h00);
    run_frame(got, low);
    step(TMO - 1);
    check("tmo_not_yet", timeout_err, 0);
    step(1);
    check("tmo_fire", timeout_err, 1);
    check("tmo_ready", req_ready, 1);
    check("tmo_no_done", done_pulse, 0);
    step(1);
    check("tmo_single", tmo_cnt - t0, 1);
    check("tmo_done_count", done_cnt - d0, 0);

    // Edge on the timeout cycle: done wins
    step(2);
    d0 = done_cnt; t0 = tmo_cnt;
    start_job(1'b0, 128'h1, 8'h02, 8'h03);
    run_frame(got, low);
    step(TMO - 1);
    miso = 1'b1;
    step(1);
    check("sim_done", done_pulse, 1);
    check("sim_no_tmo", timeout_err, 0);
    step(1);
    check("sim_tmo_count", tmo_cnt - t0, 0);
    check("sim_done_count", done_cnt - d0, 1);

    // Reset during bit 70 of SHIFT
    miso = 1'b0;
    step(2);
    d0 = done_cnt; t0 = tmo_cnt;
    start_job(1'b1, 128'hffffffffffffffffffffffffffffffff, 8'hff, 8'hff);
    step(286);
    check("mid_ss_low", ss, 0);
    check("mid_bit70", mosi, 1);
    rst = 1'b1;
    step(1);
    check("mid_rst_ss", ss, 1);
    check("mid_rst_mosi", mosi, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    step(3);
    start_job(1'b1, 128'h55aa55aa00ff00ff1234567887654321, 8'h01, 8'hfe);
    run_frame(got, low);
    check("fresh_frame", got, exp_fresh);
    check("fresh_ss_low_cycles", low, 584);
    check("mid_no_done", done_cnt - d0, 0);
    check("mid_no_tmo", tmo_cnt - t0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
